note_display_ctrl: RTL and testbench

NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

---
 rtl/note_display_ctrl.sv | 161 ++++++++++++++++
 tb/tb_note_display_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/note_display_ctrl.sv
// Note queue feeding three display slots (current, previous, one before).
// Notes advance only on frame ticks; an optional blank frame separates notes.
module note_display_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] note_in,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       frame_tick,
    input  logic [5:0] hold_frames,
    input  logic       gap_en,
    input  logic       flush,
    output logic [5:0] cur_note,
    output logic [5:0] prev_note,
    output logic [5:0] prev2_note,
    output logic [4:0] fill,
    output logic       busy
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic [5:0]      cur_q, cur_d;
    logic [5:0]      prev_q, prev_d;
    logic [5:0]      prev2_q, prev2_d;
    logic [5:0]      last_q, last_d;
    logic [5:0]      frame_cnt_q, frame_cnt_d;
    logic [5:0]      hold_len_q, hold_len_d;
    logic [5:0]      mem_q [DEPTH];
    logic [5:0]      mem_d [DEPTH];

    logic            push;
    logic            load;
    logic [5:0]      head;

    assign note_ready = (count_q != 5'(DEPTH));
    assign push       = note_valid && note_ready;
    assign head       = mem_q[rd_ptr_q];
    assign cur_note   = cur_q;
    assign prev_note  = prev_q;
    assign prev2_note = prev2_q;
    assign fill       = count_q;
    assign busy       = (state_q != IDLE) || (count_q != 5'd0);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        prev_d      = prev_q;
        prev2_d     = prev2_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;
        hold_len_d  = hold_len_q;
        load        = 1'b0;

        // Only the registered count decides a load, so a same-cycle push waits.
        unique case (state_q)
            IDLE: begin
                cur_d = 6'd0;
                if (frame_tick && count_q != 5'd0) load = 1'b1;
            end
            HOLD: begin
                if (frame_tick) begin
                    if (frame_cnt_q == hold_len_q - 6'd1) begin
                        if (gap_en) begin
                            cur_d   = 6'd0;
                            state_d = GAP;
                        end else if (count_q != 5'd0) begin
                            load = 1'b1;
                        end else begin
                            cur_d   = 6'd0;
                            state_d = IDLE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 6'd1;
                    end
                end
            end
            GAP: begin
                if (frame_tick) begin
                    if (count_q != 5'd0) load = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cur_d       = head;
            prev2_d     = prev_q;
            prev_d      = last_q;
            last_d      = head;
            frame_cnt_d = 6'd0;
            hold_len_d  = (hold_frames == 6'd0) ? 6'd1 : hold_frames;
            state_d     = HOLD;
        end

        if (flush) begin
            state_d     = IDLE;
            cur_d       = 6'd0;
            prev_d      = 6'd0;
            prev2_d     = 6'd0;
            last_d      = 6'd0;
            frame_cnt_d = 6'd0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = note_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (load) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !load) count_d = count_q + 5'd1;
        else if (!push && load) count_d = count_q - 5'd1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 5'd0;
            cur_q       <= 6'd0;
            prev_q      <= 6'd0;
            prev2_q     <= 6'd0;
            last_q      <= 6'd0;
            frame_cnt_q <= 6'd0;
            hold_len_q  <= 6'd1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            prev2_q     <= prev2_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
            hold_len_q  <= hold_len_d;
        end
    end
endmodule

// File: tb/tb_note_display_ctrl.sv
// Directed bench for note_display_ctrl with hand-computed expectations.
module tb_note_display_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] note_in;
    logic       note_valid;
    logic       note_ready;
    logic       frame_tick;
    logic [5:0] hold_frames;
    logic       gap_en;
    logic       flush;
    logic [5:0] cur_note;
    logic [5:0] prev_note;
    logic [5:0] prev2_note;
    logic [4:0] fill;
    logic       busy;

    int checks = 0;
    int failures = 0;

    note_display_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .note_in(note_in), .note_valid(note_valid), .note_ready(note_ready),
        .frame_tick(frame_tick), .hold_frames(hold_frames),
        .gap_en(gap_en), .flush(flush),
        .cur_note(cur_note), .prev_note(prev_note), .prev2_note(prev2_note),
        .fill(fill), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] v);
        note_in = v;
        note_valid = 1'b1;
        @(posedge clk); #1;
        note_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        note_in = 6'd0;
        note_valid = 1'b0;
        frame_tick = 1'b0;
        hold_frames = 6'd2;
        gap_en = 1'b0;
        flush = 1'b0;
        #3;
        chk("rst_cur", 8'(cur_note), 8'd0);
        chk("rst_fill", 8'(fill), 8'd0);
        chk("rst_ready", 8'(note_ready), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // hold 2, no gap: 13 then 26
        push(6'd13);
        push(6'd26);
        chk("a_fill", 8'(fill), 8'd2);
        chk("a_cur_pre", 8'(cur_note), 8'd0);
        tick(); chk("a_t1", 8'(cur_note), 8'd13);
        chk("a_t1_prev", 8'(prev_note), 8'd0);
        tick(); chk("a_t2", 8'(cur_note), 8'd13);
        tick(); chk("a_t3", 8'(cur_note), 8'd26);
        chk("a_t3_prev", 8'(prev_note), 8'd13);
        tick(); chk("a_t4", 8'(cur_note), 8'd26);
        chk("a_t4_prev", 8'(prev_note), 8'd13);
        tick(); chk("a_t5", 8'(cur_note), 8'd0);
        chk("a_t5_busy", 8'(busy), 8'd0);
        do_flush();
        chk("a_flush_prev", 8'(prev_note), 8'd0);

        // gap enabled, hold 1
        gap_en = 1'b1;
        hold_frames = 6'd1;
        push(6'd7);
        push(6'd7);
        tick(); chk("b_t1", 8'(cur_note), 8'd7);
        tick(); chk("b_t2", 8'(cur_note), 8'd0);
        chk("b_t2_busy", 8'(busy), 8'd1);
        tick(); chk("b_t3", 8'(cur_note), 8'd7);
        chk("b_t3_prev", 8'(prev_note), 8'd7);
        tick(); chk("b_t4", 8'(cur_note), 8'd0);
        tick(); chk("b_t5_busy", 8'(busy), 8'd0);
        chk("b_t5_cur", 8'(cur_note), 8'd0);

        // hold 0 acts as 1; display chain
        gap_en = 1'b0;
        hold_frames = 6'd0;
        push(6'd3);
        push(6'd4);
        tick(); chk("c_t1", 8'(cur_note), 8'd3);
        chk("c_t1_prev2", 8'(prev2_note), 8'd7);
        tick(); chk("c_t2", 8'(cur_note), 8'd4);
        chk("c_t2_prev", 8'(prev_note), 8'd3);
        chk("c_t2_prev2", 8'(prev2_note), 8'd7);
        tick(); chk("c_t3", 8'(cur_note), 8'd0);

        // push on the tick cycle is not loaded by that tick
        note_in = 6'd9;
        note_valid = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        note_valid = 1'b0;
        frame_tick = 1'b0;
        chk("d_same_cur", 8'(cur_note), 8'd0);
        chk("d_same_fill", 8'(fill), 8'd1);
        tick(); chk("d_next", 8'(cur_note), 8'd9);
        tick(); chk("d_end", 8'(cur_note), 8'd0);

        // hold_frames latched at load
        hold_frames = 6'd3;
        push(6'd11);
        tick(); chk("e_t1", 8'(cur_note), 8'd11);
        hold_frames = 6'd1;
        tick(); chk("e_t2", 8'(cur_note), 8'd11);
        tick(); chk("e_t3", 8'(cur_note), 8'd11);
        tick(); chk("e_t4", 8'(cur_note), 8'd0);

        // fill to DEPTH, then pop
        hold_frames = 6'd2;
        note_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            note_in = 6'(i);
            @(posedge clk); #1;
        end
        chk("f_fill", 8'(fill), 8'd4);
        chk("f_ready", 8'(note_ready), 8'd0);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        note_valid = 1'b0;
        chk("f_pop_fill", 8'(fill), 8'd3);
        chk("f_pop_ready", 8'(note_ready), 8'd1);
        chk("f_pop_cur", 8'(cur_note), 8'd1);
        do_flush();

        // flush dominates tick and push, mid-HOLD with fill 3
        push(6'd1);
        push(6'd2);
        push(6'd3);
        push(6'd4);
        tick();
        chk("g_pre_fill", 8'(fill), 8'd3);
        chk("g_pre_cur", 8'(cur_note), 8'd1);
        flush = 1'b1;
        frame_tick = 1'b1;
        note_valid = 1'b1;
        note_in = 6'd9;
        @(posedge clk); #1;
        flush = 1'b0;
        frame_tick = 1'b0;
        note_valid = 1'b0;
        chk("g_fill", 8'(fill), 8'd0);
        chk("g_cur", 8'(cur_note), 8'd0);
        chk("g_prev", 8'(prev_note), 8'd0);
        chk("g_busy", 8'(busy), 8'd0);

        // async reset mid-HOLD with fill 2
        push(6'd21);
        push(6'd22);
        push(6'd23);
        tick();
        chk("h_pre_cur", 8'(cur_note), 8'd21);
        chk("h_pre_fill", 8'(fill), 8'd2);
        #1 reset = 1'b0;
        #1;
        chk("h_rst_cur", 8'(cur_note), 8'd0);
        chk("h_rst_fill", 8'(fill), 8'd0);
        chk("h_rst_busy", 8'(busy), 8'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(); chk("h_t1", 8'(cur_note), 8'd0);
        tick(); chk("h_t2", 8'(cur_note), 8'd0);
        tick(); chk("h_t3", 8'(cur_note), 8'd0);
        chk("h_fill", 8'(fill), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
